// File: rtl/sobel_pixel_sequencer.sv
// Sobel pixel sequencer: walks a frame in raster order, feeds each interior
// pixel's six neighbour blue bytes to the Thumb core, runs it for a fixed
// time, thresholds |result| and streams one black/white pixel per position.
module sobel_pixel_sequencer #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned RUN_CYCLES = 30,
    parameter int unsigned THRESH     = 64,
    parameter logic [7:0]  RES_ADDR   = 8'd24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    output logic        fb_req,
    output logic [31:0] fb_addr,
    input  logic        fb_ack,
    input  logic [7:0]  fb_rdata,
    output logic        dm_we,
    output logic        dm_re,
    output logic [7:0]  dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        cpu_reset_n,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_data,
    output logic        pix_last,
    output logic        busy
);

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);
    localparam logic [31:0] THRESH_W = 32'(THRESH);

    typedef enum logic [3:0] {
        IDLE, CLASSIFY, FETCH, LOAD, CPU_RST, CPU_RUN, RD_RES, CAP_RES, EMIT, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] w, h, x, y;
    logic [2:0]  k;
    logic [7:0]  byte_q;
    logic [7:0]  pix_q;
    logic [31:0] cnt;

    logic        last_col, last_row, border;
    logic [31:0] nx, ny, fb_off, fb_addr_c;
    logic [31:0] mag;
    logic        white;

    // Position classification, neighbour address and result magnitude.
    always_comb begin
        last_col  = (x == w - 16'd1);
        last_row  = (y == h - 16'd1);
        border    = (x == '0) || last_col || (y == '0) || last_row;
        // k[0] picks left/right column, k[2:1] picks row offset 0..2 from y-1
        nx        = k[0] ? ({16'b0, x} + 32'd1) : ({16'b0, x} - 32'd1);
        ny        = {16'b0, y} - 32'd1 + {30'b0, k[2:1]};
        fb_off    = {16'b0, w} * ny + nx;
        fb_addr_c = FB_BASE + 32'd3 * fb_off;
        // two's-complement negate; 32'h8000_0000 maps to itself and stays large
        mag       = dm_rdata[31] ? (~dm_rdata + 32'd1) : dm_rdata;
        white     = (mag > THRESH_W);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        fb_req      = 1'b0;
        fb_addr     = '0;
        dm_we       = 1'b0;
        dm_re       = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;
        cpu_reset_n = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        pix_last    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (img_width == '0 || img_height == '0) state_nxt = DONE;
                    else                                      state_nxt = CLASSIFY;
                end
            end
            CLASSIFY: state_nxt = border ? EMIT : FETCH;
            FETCH: begin
                fb_req  = 1'b1;
                fb_addr = fb_addr_c;
                if (fb_ack) state_nxt = LOAD;
            end
            LOAD: begin
                dm_we     = 1'b1;
                dm_addr   = {3'b0, k, 2'b0};
                dm_wdata  = {24'b0, byte_q};
                state_nxt = (k == 3'd5) ? CPU_RST : FETCH;
            end
            CPU_RST: if (cnt == RST_LAST) state_nxt = CPU_RUN;
            CPU_RUN: begin
                cpu_reset_n = 1'b1;
                if (cnt == RUN_LAST) state_nxt = RD_RES;
            end
            RD_RES: begin
                dm_re     = 1'b1;
                dm_addr   = RES_ADDR;
                state_nxt = CAP_RES;
            end
            CAP_RES: state_nxt = EMIT;
            EMIT: begin
                pix_valid = 1'b1;
                pix_data  = pix_q;
                pix_last  = last_col && last_row;
                if (pix_ready) state_nxt = (last_col && last_row) ? DONE : CLASSIFY;
            end
            DONE: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: frame size, position, fetch index, run counter, pixel value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w      <= '0;
            h      <= '0;
            x      <= '0;
            y      <= '0;
            k      <= '0;
            byte_q <= '0;
            pix_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    w <= img_width;
                    h <= img_height;
                    x <= '0;
                    y <= '0;
                end
                CLASSIFY: begin
                    pix_q <= '0;
                    k     <= '0;
                end
                FETCH: if (fb_ack) byte_q <= fb_rdata;
                LOAD: begin
                    k   <= k + 3'd1;
                    cnt <= '0;
                end
                CPU_RST: cnt <= (cnt == RST_LAST) ? '0 : cnt + 32'd1;
                CPU_RUN: cnt <= cnt + 32'd1;
                CAP_RES: pix_q <= white ? 8'hFF : 8'h00;
                EMIT: if (pix_ready) begin
                    if (last_col) begin
                        x <= '0;
                        y <= y + 16'd1;
                    end else begin
                        x <= x + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_pixel_sequencer.sv
// Scoreboard bench for sobel_pixel_sequencer with frame-buffer, data-memory
// and Thumb-core behavioural models.
module tb_sobel_pixel_sequencer;

    localparam logic [31:0] FBB  = 32'h0000_0100;
    localparam int          RSTC = 2;
    localparam int          RUNC = 30;
    localparam int          THR  = 64;

    logic        clk, reset_n, start;
    logic [15:0] img_width, img_height;
    logic        fb_req, fb_ack;
    logic [31:0] fb_addr;
    logic [7:0]  fb_rdata;
    logic        dm_we, dm_re;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        cpu_reset_n;
    logic        pix_valid, pix_ready, pix_last, busy;
    logic [7:0]  pix_data;

    sobel_pixel_sequencer #(
        .FB_BASE(FBB), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC),
        .THRESH(THR), .RES_ADDR(8'd24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .img_width(img_width), .img_height(img_height),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack), .fb_rdata(fb_rdata),
        .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .cpu_reset_n(cpu_reset_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_last(pix_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0]  exp_pix[$];
    logic [31:0] exp_fb[$];
    logic [39:0] exp_dm[$];
    int          exp_runs = 0;
    logic [7:0]  fbmem[int unsigned];
    logic [31:0] dm[0:63];
    bit          force_res = 1'b0;
    logic [31:0] force_val = '0;
    int          ready_mode = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_unexp(string name, logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Horizontal Sobel gradient over the six neighbours.
    function automatic int gx6(int b0, int b1, int b2, int b3, int b4, int b5);
        return (b1 - b0) + 2 * (b3 - b2) + (b5 - b4);
    endfunction

    function automatic logic [31:0] pix_addr(int w, int px, int py);
        return FBB + 32'(3 * (w * py + px));
    endfunction

    // Reference: expected fetches, dm writes and output pixels for a frame.
    task automatic model_frame(int w, int h);
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                bit  last = (px == w - 1) && (py == h - 1);
                bit  brd  = (px == 0) || (px == w - 1) || (py == 0) || (py == h - 1);
                int  b[6];
                longint r, mag;
                if (brd) begin
                    exp_pix.push_back({last, 8'h00});
                end else begin
                    int nb[6][2] = '{'{-1,-1}, '{1,-1}, '{-1,0}, '{1,0}, '{-1,1}, '{1,1}};
                    for (int n = 0; n < 6; n++) begin
                        logic [31:0] a = pix_addr(w, px + nb[n][0], py + nb[n][1]);
                        b[n] = fbmem.exists(a) ? int'(fbmem[a]) : 0;
                        exp_fb.push_back(a);
                        exp_dm.push_back({8'(4 * n), 32'(b[n])});
                    end
                    exp_runs++;
                    r   = force_res ? longint'($signed(force_val))
                                    : longint'(gx6(b[0], b[1], b[2], b[3], b[4], b[5]));
                    mag = (r < 0) ? -r : r;
                    exp_pix.push_back({last, (mag > THR) ? 8'hFF : 8'h00});
                end
            end
        end
    endtask

    task automatic fill_image(int w, int h);
        fbmem.delete();
        for (int py = 0; py < h; py++)
            for (int px = 0; px < w; px++)
                fbmem[pix_addr(w, px, py)] = 8'($urandom);
    endtask

    task automatic fill_3x3_fixed();
        fill_image(3, 3);
        fbmem[pix_addr(3, 0, 0)] = 8'd10;
        fbmem[pix_addr(3, 2, 0)] = 8'd13;
        fbmem[pix_addr(3, 0, 1)] = 8'd15;
        fbmem[pix_addr(3, 2, 1)] = 8'd11;
        fbmem[pix_addr(3, 0, 2)] = 8'd8;
        fbmem[pix_addr(3, 2, 2)] = 8'd17;
    endtask

    // Frame-buffer responder with random ack latency.
    initial begin : fb_model
        int dcnt, dly;
        bit held;
        logic [31:0] held_addr;
        fb_ack = 1'b0; fb_rdata = '0; dcnt = 0; dly = 0; held = 1'b0; held_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                fb_ack = 1'b0; dcnt = 0; held = 1'b0;
            end else if (fb_ack) begin
                fb_ack = 1'b0;
                chk("fb_req_drop", fb_req, 1'b0);
            end else if (fb_req) begin
                if (held) chk("fb_addr_stable", fb_addr, held_addr);
                if (dcnt < dly) begin
                    dcnt++; held = 1'b1; held_addr = fb_addr;
                end else begin
                    if (exp_fb.size() == 0) fail_unexp("fb_unexpected_req", fb_addr);
                    else chk("fb_addr", fb_addr, exp_fb.pop_front());
                    fb_rdata = fbmem.exists(fb_addr) ? fbmem[fb_addr] : 8'hEE;
                    fb_ack = 1'b1; dcnt = 0; dly = $urandom_range(0, 2); held = 1'b0;
                end
            end
        end
    end

    // Data memory (one-cycle read latency) plus core model that writes its
    // gradient result to word 6 while released.
    initial begin : dm_model
        logic [31:0] pend;
        logic [39:0] e;
        pend = '0; dm_rdata = '0;
        for (int i = 0; i < 64; i++) dm[i] = '0;
        forever begin
            @(negedge clk);
            dm_rdata = pend;
            pend = 32'hDEAD_BEEF;
            if (reset_n) begin
                if (dm_we) begin
                    if (exp_dm.size() == 0) fail_unexp("dm_unexpected_we", {dm_addr, dm_wdata});
                    else begin
                        e = exp_dm.pop_front();
                        chk("dm_write", {dm_addr, dm_wdata}, e);
                    end
                    dm[dm_addr[7:2]] = dm_wdata;
                end
                if (dm_re) begin
                    chk("dm_re_addr", dm_addr, 8'd24);
                    pend = dm[dm_addr[7:2]];
                end
                if (cpu_reset_n)
                    dm[6] = force_res ? force_val
                          : 32'(gx6(int'(dm[0][7:0]), int'(dm[1][7:0]), int'(dm[2][7:0]),
                                    int'(dm[3][7:0]), int'(dm[4][7:0]), int'(dm[5][7:0])));
            end
        end
    end

    // Core release monitor: each release must last exactly RUNC cycles.
    initial begin : run_mon
        int run_len;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) run_len = 0;
            else if (cpu_reset_n) begin
                run_len++;
                if (run_len == 1) begin
                    if (exp_runs == 0) fail_unexp("cpu_unexpected_release", 1);
                    else exp_runs--;
                end
            end else if (run_len > 0) begin
                chk("cpu_run_len", run_len, RUNC);
                run_len = 0;
            end
        end
    end

    // Output sink and pixel scoreboard.
    initial begin : pix_mon
        bit pv;
        int stall;
        logic [8:0] pprev, e;
        pv = 1'b0; stall = 0; pprev = '0; pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0; stall = 0; pix_ready = 1'b0;
            end else begin
                if (pv) begin
                    chk("pix_hold_valid", pix_valid, 1'b1);
                    chk("pix_hold_data", {pix_last, pix_data}, pprev);
                end
                if (ready_mode == 2 && pix_valid && stall < 5) begin
                    pix_ready = 1'b0; stall++;
                end else if (ready_mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
                else pix_ready = 1'b1;
                if (pix_valid && pix_ready) begin
                    if (exp_pix.size() == 0) fail_unexp("pix_unexpected", {pix_last, pix_data});
                    else begin
                        e = exp_pix.pop_front();
                        chk("pix_out", {pix_last, pix_data}, e);
                    end
                    stall = 0; pv = 1'b0;
                end else if (pix_valid) begin
                    pv = 1'b1; pprev = {pix_last, pix_data};
                end else pv = 1'b0;
            end
        end
    end

    task automatic run_frame(int w, int h, bit poke);
        bit timed_out;
        int limit;
        model_frame(w, h);
        @(negedge clk);
        img_width = 16'(w); img_height = 16'(h); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (w > 0 && h > 0) chk("busy_after_start", busy, 1'b1);
        if (poke) begin
            repeat (8) @(negedge clk);
            img_width = 16'd7; img_height = 16'd7; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        limit = w * h * 150 + 200;
        timed_out = 1'b1;
        for (int c = 0; c < limit; c++) begin
            if (exp_pix.size() == 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("frame_timeout", timed_out, 1'b0);
        chk("fb_left", exp_fb.size(), 0);
        chk("dm_left", exp_dm.size(), 0);
        chk("runs_left", exp_runs, 0);
        chk("cpu_rst_idle", cpu_reset_n, 1'b0);
    endtask

    initial begin : main
        bit seen;
        reset_n = 1'b0; start = 1'b0; img_width = '0; img_height = '0;
        repeat (3) @(negedge clk);
        chk("rst_fb_req", fb_req, 1'b0);
        chk("rst_fb_addr", fb_addr, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cpu_reset_n", cpu_reset_n, 1'b0);
        chk("rst_pix_valid", pix_valid, 1'b0);
        chk("rst_pix_data", pix_data, 8'h00);
        chk("rst_dm", {dm_we, dm_re, dm_addr, dm_wdata}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset while a fetch is outstanding.
        fill_3x3_fixed();
        model_frame(3, 3);
        img_width = 16'd3; img_height = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (fb_req) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("reach_fetch", seen, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_fb_req", fb_req, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cpu_reset_n", cpu_reset_n, 1'b0);
        chk("arst_pix_valid", pix_valid, 1'b0);
        exp_pix.delete(); exp_fb.delete(); exp_dm.delete(); exp_runs = 0;
        @(negedge clk);
        chk("arst2_fb_req", fb_req, 1'b0);
        chk("arst2_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Fixed 3x3 window, gradient 4 -> black.
        run_frame(3, 3, 1'b0);

        // Forced core results around the threshold.
        force_res = 1'b1;
        force_val = -32'sd65;        run_frame(3, 3, 1'b0);
        force_val = 32'd64;          run_frame(3, 3, 1'b0);
        force_val = 32'h8000_0000;   run_frame(3, 3, 1'b0);
        force_val = 32'd65;          run_frame(3, 3, 1'b0);
        force_res = 1'b0;

        // 4x3 frame: fetch addresses of two adjacent interior pixels.
        fill_image(4, 3);
        run_frame(4, 3, 1'b0);

        // Downstream stalls of five cycles per pixel.
        ready_mode = 2;
        fill_3x3_fixed();
        run_frame(3, 3, 1'b0);
        fill_image(4, 3);
        run_frame(4, 3, 1'b0);
        ready_mode = 0;

        // Start while busy, then an all-border frame.
        fill_3x3_fixed();
        run_frame(3, 3, 1'b1);
        fbmem.delete();
        run_frame(2, 5, 1'b0);
        run_frame(1, 4, 1'b0);
        run_frame(0, 3, 1'b0);
        run_frame(3, 0, 1'b0);

        // Random frames with random backpressure.
        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            int w = $urandom_range(3, 7);
            int h = $urandom_range(3, 5);
            fill_image(w, h);
            run_frame(w, h, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_pixel_sequencer.md
Name: sobel_pixel_sequencer

Overview:
- Hardware controller that replaces the software pixel loop around the Thumb core in the Sobel edge-detection flow.
- Walks a 24-bit BMP frame in raster order and fetches the six neighbour blue bytes of each interior pixel from a frame buffer.
- Loads those bytes into the core's data memory, restarts the core, and waits a fixed run time.
- Reads the core's result, takes its absolute value, thresholds it, and streams one black/white output pixel per frame position.

Parameters:
- FB_BASE, 32'h0000_0000, byte address of pixel (0,0) in the frame buffer.
- RST_CYCLES, 2, cycles cpu_reset_n is held low after a window is loaded.
- RUN_CYCLES, 30, core run cycles before the result is read.
- THRESH, 64, edge threshold; |result| > THRESH gives white.
- RES_ADDR, 8'd24, data-memory byte address of the core's result word.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless idle.
- img_width  in  16  pixels per row; sampled on start.
- img_height  in  16  rows; sampled on start.
- fb_req  out  1  frame-buffer read request.
- fb_addr  out  32  frame-buffer byte address.
- fb_ack  in  1  read complete; fb_rdata valid in the same cycle.
- fb_rdata  in  8  byte read.
- dm_we  out  1  data-memory write strobe.
- dm_re  out  1  data-memory read strobe.
- dm_addr  out  8  data-memory byte address.
- dm_wdata  out  32  data-memory write data.
- dm_rdata  in  32  read data, valid one cycle after dm_re.
- cpu_reset_n  out  1  active-low reset to the Thumb core.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  8  0x00 or 0xFF; the sink replicates it to B, G and R.
- pix_last  out  1  marks the final pixel of the frame.
- busy  out  1  high from start until the final pixel is accepted.

Behaviour:
- Reset values: all outputs 0, cpu_reset_n 0; state IDLE, x = y = 0.
- States: IDLE, CLASSIFY, FETCH, LOAD, CPU_RST, CPU_RUN, RD_RES, CAP_RES, EMIT, DONE.
- IDLE -> CLASSIFY on start. In IDLE, busy=0 and cpu_reset_n=0.
  - A frame with W<3 or H<3 is all border: every pixel emits 0x00 and the core is never released.
  - W=0 or H=0 means no pixels: go to DONE directly with no EMIT.
- CLASSIFY: a pixel is border if x==0, x==W-1, y==0 or y==H-1.
  - Border: set pix_data=0x00 and go to EMIT.
  - Interior: set k=0 and go to FETCH.
- FETCH:
  - Neighbour k order: (x-1,y-1), (x+1,y-1), (x-1,y), (x+1,y), (x-1,y+1), (x+1,y+1).
  - fb_addr = FB_BASE + 3*(W*yy+xx), computed in 32 bits.
  - fb_req and fb_addr are held stable until fb_ack; fb_req drops the cycle after fb_ack. No timeout.
  - On fb_ack, latch fb_rdata and go to LOAD.
- LOAD: one-cycle pulse of dm_we with dm_addr=4*k and dm_wdata={24'b0, byte}.
  - k<5: k++ and return to FETCH.
  - k==5: go to CPU_RST.
- cpu_reset_n stays 0 from CLASSIFY through CPU_RST. CPU_RST lasts exactly RST_CYCLES cycles.
- CPU_RUN: cpu_reset_n=1 for exactly RUN_CYCLES cycles, then go to RD_RES.
- RD_RES: cpu_reset_n=0 (freezes the core) and a one-cycle dm_re with dm_addr=RES_ADDR.
- CAP_RES: capture dm_rdata as signed r.
  - mag = r<0 ? -r : r, treated as unsigned 32-bit; 32'h8000_0000 counts as large.
  - pix_data = (mag > THRESH) ? 8'hFF : 8'h00. Go to EMIT.
- EMIT: pix_valid=1, with pix_data and pix_last held stable until pix_valid && pix_ready. A pixel is never dropped or repeated.
  - On acceptance, x++; if x==W-1, x=0 and y++.
  - If the accepted pixel was the last (x==W-1 and y==H-1): go to DONE, else to CLASSIFY.
- DONE: busy=0 for one cycle, then IDLE.
- start while busy: ignored; the current frame continues unchanged.
- reset_n asserted mid-operation: immediate return to reset values.
  - Any in-flight fb or dm access is abandoned; cpu_reset_n goes low asynchronously.
- Interior pixel cycle count, with zero-wait fb_ack and pix_ready=1: 1 + 6×(F+1) + RST_CYCLES + RUN_CYCLES + 2 + 1, where F = fb_ack latency in cycles (≥1).

Test Plan:
- Reset mid-FETCH (fb_req=1) -> next cycle: fb_req=0, busy=0, cpu_reset_n=0, pix_valid=0; a new start runs correctly.
- 3x3 frame, start, fb returns the centre window 10,13,15,11,8,17, core model writes 4 to addr 24 -> 9 pixels emitted; only pixel (1,1) triggers fetches.
  - dm writes addr 0,4,...,20 with those values in order; pix_data=0x00 (4≤64).
  - pix_last=1 only on the 9th pixel.
- Same frame with core result -65 -> centre pixel 0xFF. Result 64 -> 0x00. Result 32'h8000_0000 -> 0xFF.
- 4x3 frame, FB_BASE=0x100 -> fetch addresses for (1,1) are 0x100, 0x106, 0x10C, 0x112, 0x118, 0x11E; for (2,1) each address is +3.
- pix_ready held low 5 cycles during EMIT -> pix_valid and pix_data stable throughout; x advances exactly once on acceptance.
- start pulsed while busy; then W=2, H=5 frame -> second start ignored; 10 pixels all 0x00, no fb_req, cpu_reset_n stays 0.
